// File: rtl/multicycle_control_fsm_if.sv
// Signal bundle between the multicycle sequencer and the datapath it steers.
// master: the sequencer (consumes decode fields and status, drives controls).
// slave:  the datapath side (drives decode fields and status, consumes controls).
interface multicycle_control_fsm_if;
    logic [6:0] Op;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       Zero;
    logic       mem_ready;
    logic       PCWrite;
    logic       AdrSrc;
    logic       IRWrite;
    logic       MemWrite;
    logic       RegWrite;
    logic [1:0] ResultSrc;
    logic [1:0] ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] ImmSrc;
    logic [2:0] ALUControl;
    logic       InstrDone;
    logic [1:0] Fault;
    logic [3:0] State;

    modport master (
        input  Op, funct3, funct7, Zero, mem_ready,
        output PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, Fault, State
    );

    modport slave (
        output Op, funct3, funct7, Zero, mem_ready,
        input  PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
               ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, Fault, State
    );
endinterface

// File: rtl/multicycle_control_fsm.sv
// Multicycle core sequencer: walks one instruction through FETCH/DECODE/
// EXECUTE/MEM/WB, waits on mem_ready, and traps illegal encodings and memory
// timeouts into a sticky FAULT state that only rst leaves.
// Handshake: in FETCH/MEMREAD/MEMWRITE the access is held (address/strobe
// stable) every cycle until mem_ready=1, which completes it in that same
// cycle; mem_ready is don't-care in every other state.
module multicycle_control_fsm #(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 5
) (
    input  logic                       clk,
    input  logic                       rst,
    multicycle_control_fsm_if.master   bus
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_JAL      = 4'd10,
        S_FAULT    = 4'd15
    } state_t;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_TIMEOUT = 2'b10;

    state_t             r_state;
    state_t             w_state_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [1:0]         r_fault;
    logic [1:0]         w_fault_code;

    logic               w_mem_state;
    logic               w_timeout;
    logic               w_alu_ok;
    logic [2:0]         w_alu_ctrl;
    logic               w_br_ok;
    logic               w_unused_funct7;

    logic               w_pc_write;
    logic               w_adr_src;
    logic               w_ir_write;
    logic               w_mem_write;
    logic               w_reg_write;
    logic [1:0]         w_result_src;
    logic [1:0]         w_alu_src_a;
    logic [1:0]         w_alu_src_b;
    logic [1:0]         w_imm_src;
    logic [2:0]         w_alu_control;
    logic               w_instr_done;

    // Only funct7[5] selects sub; the remaining bits are deliberately ignored.
    assign w_unused_funct7 = ^{bus.funct7[6], bus.funct7[4:0]};

    // States that wait on memory and therefore run the timeout counter.
    assign w_mem_state = (r_state == S_FETCH) || (r_state == S_MEMREAD) ||
                         (r_state == S_MEMWRITE);

    // Limit reached while memory is still busy; mem_ready on the limit cycle wins.
    assign w_timeout = (MEM_TIMEOUT != 0) && w_mem_state && !bus.mem_ready &&
                       (r_cnt == CNT_W'(MEM_TIMEOUT));

    // ALU operation decode from funct3 (sub only for register-register forms).
    always_comb begin
        w_alu_ok   = 1'b1;
        w_alu_ctrl = 3'b000;
        case (bus.funct3)
            3'b000:  w_alu_ctrl = (bus.Op[5] && bus.funct7[5]) ? 3'b001 : 3'b000;
            3'b010:  w_alu_ctrl = 3'b101;
            3'b110:  w_alu_ctrl = 3'b011;
            3'b111:  w_alu_ctrl = 3'b010;
            default: w_alu_ok   = 1'b0;
        endcase
    end

    assign w_br_ok = (bus.funct3 == 3'b000) || (bus.funct3 == 3'b001);

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_FETCH;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Wait counter (cleared on every state change) and sticky fault code.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt   <= '0;
            r_fault <= FAULT_NONE;
        end else begin
            if (w_state_next != r_state) begin
                r_cnt <= '0;
            end else if (w_mem_state && !bus.mem_ready && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
            if ((w_state_next == S_FAULT) && (r_state != S_FAULT)) begin
                r_fault <= w_fault_code;
            end
        end
    end

    // Next-state selection and the fault code recorded on entry to FAULT.
    always_comb begin
        w_state_next = r_state;
        w_fault_code = FAULT_NONE;
        case (r_state)
            S_FETCH: begin
                if (bus.mem_ready) begin
                    w_state_next = S_DECODE;
                end else if (w_timeout) begin
                    w_state_next = S_FAULT;
                    w_fault_code = FAULT_TIMEOUT;
                end
            end
            S_DECODE: begin
                case (bus.Op)
                    OP_LOAD, OP_STORE: w_state_next = S_MEMADR;
                    OP_R:              w_state_next = S_EXECR;
                    OP_I:              w_state_next = S_EXECI;
                    OP_BR:             w_state_next = S_BRANCH;
                    OP_JAL:            w_state_next = S_JAL;
                    default: begin
                        w_state_next = S_FAULT;
                        w_fault_code = FAULT_ILLEGAL;
                    end
                endcase
            end
            S_MEMADR: begin
                w_state_next = (bus.Op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
            end
            S_MEMREAD: begin
                if (bus.mem_ready) begin
                    w_state_next = S_MEMWB;
                end else if (w_timeout) begin
                    w_state_next = S_FAULT;
                    w_fault_code = FAULT_TIMEOUT;
                end
            end
            S_MEMWB: w_state_next = S_FETCH;
            S_MEMWRITE: begin
                if (bus.mem_ready) begin
                    w_state_next = S_FETCH;
                end else if (w_timeout) begin
                    w_state_next = S_FAULT;
                    w_fault_code = FAULT_TIMEOUT;
                end
            end
            S_EXECR, S_EXECI: begin
                if (w_alu_ok) begin
                    w_state_next = S_ALUWB;
                end else begin
                    w_state_next = S_FAULT;
                    w_fault_code = FAULT_ILLEGAL;
                end
            end
            S_ALUWB: w_state_next = S_FETCH;
            S_BRANCH: begin
                if (w_br_ok) begin
                    w_state_next = S_FETCH;
                end else begin
                    w_state_next = S_FAULT;
                    w_fault_code = FAULT_ILLEGAL;
                end
            end
            S_JAL:   w_state_next = S_ALUWB;
            S_FAULT: w_state_next = S_FAULT;
            default: begin
                w_state_next = S_FAULT;
                w_fault_code = FAULT_ILLEGAL;
            end
        endcase
    end

    // Per-state enables and mux selects; rst masks every write enable.
    always_comb begin
        w_pc_write    = 1'b0;
        w_adr_src     = 1'b0;
        w_ir_write    = 1'b0;
        w_mem_write   = 1'b0;
        w_reg_write   = 1'b0;
        w_result_src  = 2'b00;
        w_alu_src_a   = 2'b00;
        w_alu_src_b   = 2'b00;
        w_imm_src     = 2'b00;
        w_alu_control = 3'b000;
        w_instr_done  = 1'b0;
        case (r_state)
            S_FETCH: begin
                w_alu_src_b  = 2'b10;
                w_result_src = 2'b10;
                w_ir_write   = bus.mem_ready;
                w_pc_write   = bus.mem_ready;
            end
            S_DECODE: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b01;
                w_imm_src   = 2'b10;
            end
            S_MEMADR: begin
                w_alu_src_a = 2'b10;
                w_alu_src_b = 2'b01;
                w_imm_src   = (bus.Op == OP_STORE) ? 2'b01 : 2'b00;
            end
            S_MEMREAD: begin
                w_adr_src = 1'b1;
            end
            S_MEMWB: begin
                w_result_src = 2'b01;
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_MEMWRITE: begin
                w_adr_src    = 1'b1;
                w_mem_write  = !w_timeout;
                w_instr_done = bus.mem_ready;
            end
            S_EXECR: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = w_alu_ctrl;
            end
            S_EXECI: begin
                w_alu_src_a   = 2'b10;
                w_alu_src_b   = 2'b01;
                w_alu_control = w_alu_ctrl;
            end
            S_ALUWB: begin
                w_reg_write  = 1'b1;
                w_instr_done = 1'b1;
            end
            S_BRANCH: begin
                w_alu_src_a   = 2'b10;
                w_alu_control = 3'b001;
                w_instr_done  = w_br_ok;
                if (bus.funct3 == 3'b000) begin
                    w_pc_write = bus.Zero;
                end else if (bus.funct3 == 3'b001) begin
                    w_pc_write = !bus.Zero;
                end
            end
            S_JAL: begin
                w_alu_src_a = 2'b01;
                w_alu_src_b = 2'b10;
                w_imm_src   = 2'b11;
                w_pc_write  = 1'b1;
            end
            default: begin
            end
        endcase
        if (rst) begin
            w_pc_write   = 1'b0;
            w_ir_write   = 1'b0;
            w_mem_write  = 1'b0;
            w_reg_write  = 1'b0;
            w_instr_done = 1'b0;
        end
    end

    assign bus.PCWrite    = w_pc_write;
    assign bus.AdrSrc     = w_adr_src;
    assign bus.IRWrite    = w_ir_write;
    assign bus.MemWrite   = w_mem_write;
    assign bus.RegWrite   = w_reg_write;
    assign bus.ResultSrc  = w_result_src;
    assign bus.ALUSrcA    = w_alu_src_a;
    assign bus.ALUSrcB    = w_alu_src_b;
    assign bus.ImmSrc     = w_imm_src;
    assign bus.ALUControl = w_alu_control;
    assign bus.InstrDone  = w_instr_done;
    assign bus.Fault      = r_fault;
    assign bus.State      = r_state;

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Bench for multicycle_control_fsm: each scenario queues per-cycle stimulus
// with the expected output vector, then replays it and compares every cycle.
module tb_multicycle_control_fsm;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    multicycle_control_fsm_if bus ();

    multicycle_control_fsm #(.MEM_TIMEOUT(16), .CNT_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // {State, PCWrite, AdrSrc, IRWrite, MemWrite, RegWrite, ResultSrc,
    //  ALUSrcA, ALUSrcB, ImmSrc, ALUControl, InstrDone, Fault}
    wire [22:0] w_obs = {bus.State, bus.PCWrite, bus.AdrSrc, bus.IRWrite,
                         bus.MemWrite, bus.RegWrite, bus.ResultSrc, bus.ALUSrcA,
                         bus.ALUSrcB, bus.ImmSrc, bus.ALUControl, bus.InstrDone,
                         bus.Fault};

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       zero;
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
    } stim_t;

    stim_t       stim_q[$];
    logic [22:0] exp_q[$];
    int          n_checks = 0;
    int          n_fail   = 0;

    logic [6:0] cur_op;
    logic [2:0] cur_f3;
    logic [6:0] cur_f7;

    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_BR    = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    function automatic logic [22:0] ev(input logic [3:0] st, input logic pcw,
                                       input logic adr, input logic irw,
                                       input logic mw, input logic rw,
                                       input logic [1:0] rs, input logic [1:0] sa,
                                       input logic [1:0] sb, input logic [1:0] imm,
                                       input logic [2:0] alu, input logic done,
                                       input logic [1:0] flt);
        return {st, pcw, adr, irw, mw, rw, rs, sa, sb, imm, alu, done, flt};
    endfunction

    function automatic logic [22:0] v_fetch(input logic ok, input logic [1:0] flt);
        return ev(4'd0, ok, 1'b0, ok, 1'b0, 1'b0, 2'd2, 2'd0, 2'd2, 2'd0, 3'd0, 1'b0, flt);
    endfunction

    function automatic logic [22:0] v_decode();
        return ev(4'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd1, 2'd1, 2'd2, 3'd0, 1'b0, 2'd0);
    endfunction

    function automatic logic [22:0] v_aluwb();
        return ev(4'd8, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b1, 2'd0);
    endfunction

    function automatic logic [22:0] v_fault(input logic [1:0] flt);
        return ev(4'd15, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 1'b0, flt);
    endfunction

    function automatic logic [22:0] v_memwrite(input logic mw, input logic done);
        return ev(4'd5, 1'b0, 1'b1, 1'b0, mw, 1'b0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, done, 2'd0);
    endfunction

    function automatic logic [22:0] v_memadr(input logic [1:0] imm);
        return ev(4'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 2'd2, 2'd1, imm, 3'd0, 1'b0, 2'd0);
    endfunction

    task automatic push(input logic r, input logic m, input logic z, input logic [22:0] e);
        stim_t s;
        s = '{rst: r, mr: m, zero: z, op: cur_op, f3: cur_f3, f7: cur_f7};
        stim_q.push_back(s);
        exp_q.push_back(e);
    endtask

    // Applies one cycle of stimulus and waits to the sampling point (negedge).
    task automatic apply(input stim_t s);
        rst           = s.rst;
        bus.mem_ready = s.mr;
        bus.Zero      = s.zero;
        bus.Op        = s.op;
        bus.funct3    = s.f3;
        bus.funct7    = s.f7;
        @(negedge clk);
    endtask

    task automatic test_reset();
        stim_t s;
        logic [22:0] e;
        int cyc;
        cur_op = OP_R; cur_f3 = 3'b000; cur_f7 = 7'd0;
        rst = 1'b1; bus.mem_ready = 1'b1; bus.Zero = 1'b0;
        bus.Op = cur_op; bus.funct3 = cur_f3; bus.funct7 = cur_f7;
        repeat (2) @(posedge clk);
        #1;
        push(1'b1, 1'b1, 1'b0, v_fetch(1'b0, 2'd0));
        push(1'b1, 1'b1, 1'b0, v_fetch(1'b0, 2'd0));
        cyc = 0;
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s);
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL reset cyc%0d: got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_alu();
        stim_t s;
        logic [22:0] e;
        int cyc;
        logic [6:0] t_op[8];
        logic [2:0] t_f3[8];
        logic [6:0] t_f7[8];
        logic [2:0] t_alu[8];
        t_op[0] = OP_R; t_f3[0] = 3'b000; t_f7[0] = 7'b0000000; t_alu[0] = 3'b000;
        t_op[1] = OP_R; t_f3[1] = 3'b000; t_f7[1] = 7'b0100000; t_alu[1] = 3'b001;
        t_op[2] = OP_R; t_f3[2] = 3'b010; t_f7[2] = 7'b0000000; t_alu[2] = 3'b101;
        t_op[3] = OP_R; t_f3[3] = 3'b110; t_f7[3] = 7'b0000000; t_alu[3] = 3'b011;
        t_op[4] = OP_R; t_f3[4] = 3'b111; t_f7[4] = 7'b0000000; t_alu[4] = 3'b010;
        t_op[5] = OP_I; t_f3[5] = 3'b000; t_f7[5] = 7'b0100000; t_alu[5] = 3'b000;
        t_op[6] = OP_I; t_f3[6] = 3'b111; t_f7[6] = 7'($urandom_range(0, 127)); t_alu[6] = 3'b010;
        t_op[7] = OP_I; t_f3[7] = 3'b010; t_f7[7] = 7'($urandom_range(0, 127)); t_alu[7] = 3'b101;
        for (int i = 0; i < 8; i++) begin
            cur_op = t_op[i]; cur_f3 = t_f3[i]; cur_f7 = t_f7[i];
            push(1'b0, 1'b1, 1'b0, v_fetch(1'b1, 2'd0));
            push(1'b0, 1'($urandom_range(0, 1)), 1'b0, v_decode());
            if (t_op[i] == OP_R)
                push(1'b0, 1'($urandom_range(0, 1)), 1'b0,
                     ev(4'd6, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd0, t_alu[i], 0, 2'd0));
            else
                push(1'b0, 1'($urandom_range(0, 1)), 1'b0,
                     ev(4'd7, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd1, 2'd0, t_alu[i], 0, 2'd0));
            push(1'b0, 1'($urandom_range(0, 1)), 1'b0, v_aluwb());
        end
        cyc = 0;
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s);
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL alu cyc%0d: got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_load();
        stim_t s;
        logic [22:0] e;
        int cyc;
        cur_op = OP_LOAD; cur_f3 = 3'b010; cur_f7 = 7'd0;
        push(1'b0, 1'b0, 1'b0, v_fetch(1'b0, 2'd0));
        push(1'b0, 1'b0, 1'b0, v_fetch(1'b0, 2'd0));
        push(1'b0, 1'b1, 1'b0, v_fetch(1'b1, 2'd0));
        push(1'b0, 1'b0, 1'b0, v_decode());
        push(1'b0, 1'b1, 1'b0, v_memadr(2'd0));
        for (int k = 0; k < 4; k++)
            push(1'b0, (k == 3), 1'b0,
                 ev(4'd3, 0, 1, 0, 0, 0, 2'd0, 2'd0, 2'd0, 2'd0, 3'd0, 0, 2'd0));
        push(1'b0, 1'b0, 1'b0, ev(4'd4, 0, 0, 0, 0, 1, 2'd1, 2'd0, 2'd0, 2'd0, 3'd0, 1, 2'd0));
        cyc = 0;
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s);
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL load cyc%0d: got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_branch();
        stim_t s;
        logic [22:0] e;
        int cyc;
        logic [2:0] b_f3[4];
        logic       b_z[4];
        logic       b_pcw[4];
        b_f3[0] = 3'b000; b_z[0] = 1'b1; b_pcw[0] = 1'b1;
        b_f3[1] = 3'b000; b_z[1] = 1'b0; b_pcw[1] = 1'b0;
        b_f3[2] = 3'b001; b_z[2] = 1'b1; b_pcw[2] = 1'b0;
        b_f3[3] = 3'b001; b_z[3] = 1'b0; b_pcw[3] = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cur_op = OP_BR; cur_f3 = b_f3[i]; cur_f7 = 7'd0;
            push(1'b0, 1'b1, 1'($urandom_range(0, 1)), v_fetch(1'b1, 2'd0));
            push(1'b0, 1'b0, 1'($urandom_range(0, 1)), v_decode());
            push(1'b0, 1'($urandom_range(0, 1)), b_z[i],
                 ev(4'd9, b_pcw[i], 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd0, 3'b001, 1, 2'd0));
        end
        cyc = 0;
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s);
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL branch cyc%0d: got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_jal();
        stim_t s;
        logic [22:0] e;
        int cyc;
        cur_op = OP_JAL; cur_f3 = 3'($urandom_range(0, 7)); cur_f7 = 7'd0;
        push(1'b0, 1'b1, 1'b0, v_fetch(1'b1, 2'd0));
        push(1'b0, 1'b1, 1'b0, v_decode());
        push(1'b0, 1'b0, 1'b0, ev(4'd10, 1, 0, 0, 0, 0, 2'd0, 2'd1, 2'd2, 2'd3, 3'd0, 0, 2'd0));
        push(1'b0, 1'b0, 1'b0, v_aluwb());
        cyc = 0;
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s);
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL jal cyc%0d: got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_fetch_timeout();
        stim_t s;
        logic [22:0] e;
        int cyc;
        cur_op = OP_R; cur_f3 = 3'b000; cur_f7 = 7'd0;
        // 16 waiting cycles, then the limit cycle still without mem_ready
        for (int k = 0; k < 17; k++) push(1'b0, 1'b0, 1'b0, v_fetch(1'b0, 2'd0));
        push(1'b0, 1'b1, 1'b0, v_fault(2'b10));
        push(1'b0, 1'b0, 1'b0, v_fault(2'b10));
        push(1'b1, 1'b1, 1'b0, v_fault(2'b10));
        push(1'b0, 1'b0, 1'b0, v_fetch(1'b0, 2'd0));
        cyc = 0;
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s);
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL fetch_timeout cyc%0d: got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_illegal();
        stim_t s;
        logic [22:0] e;
        int cyc;
        cur_op = 7'b1111111; cur_f3 = 3'b000; cur_f7 = 7'd0;
        push(1'b0, 1'b1, 1'b0, v_fetch(1'b1, 2'd0));
        push(1'b0, 1'b1, 1'b0, v_decode());
        for (int k = 0; k < 10; k++)
            push(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), v_fault(2'b01));
        push(1'b1, 1'b1, 1'b0, v_fault(2'b01));
        push(1'b0, 1'b0, 1'b0, v_fetch(1'b0, 2'd0));
        // R-type with an unsupported funct3 traps out of EXECR
        cur_op = OP_R; cur_f3 = 3'b001;
        push(1'b0, 1'b1, 1'b0, v_fetch(1'b1, 2'd0));
        push(1'b0, 1'b1, 1'b0, v_decode());
        push(1'b0, 1'b1, 1'b0, ev(4'd6, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd0, 3'd0, 0, 2'd0));
        push(1'b0, 1'b1, 1'b0, v_fault(2'b01));
        push(1'b1, 1'b0, 1'b0, v_fault(2'b01));
        push(1'b0, 1'b0, 1'b0, v_fetch(1'b0, 2'd0));
        cyc = 0;
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s);
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL illegal cyc%0d: got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_store();
        stim_t s;
        logic [22:0] e;
        int cyc;
        int ready_at[2];
        ready_at[0] = 16;   // ready on the last normal waiting cycle
        ready_at[1] = 17;   // ready exactly on the limit cycle
        cur_op = OP_STORE; cur_f3 = 3'b010; cur_f7 = 7'd0;
        for (int i = 0; i < 2; i++) begin
            push(1'b0, 1'b1, 1'b0, v_fetch(1'b1, 2'd0));
            push(1'b0, 1'b1, 1'b0, v_decode());
            push(1'b0, 1'b1, 1'b0, v_memadr(2'd1));
            for (int k = 1; k <= ready_at[i]; k++)
                push(1'b0, (k == ready_at[i]), 1'b0, v_memwrite(1'b1, (k == ready_at[i])));
        end
        // memory never answers: 16 strobe cycles, a silent limit cycle, then FAULT
        push(1'b0, 1'b1, 1'b0, v_fetch(1'b1, 2'd0));
        push(1'b0, 1'b0, 1'b0, v_decode());
        push(1'b0, 1'b0, 1'b0, v_memadr(2'd1));
        for (int k = 0; k < 16; k++) push(1'b0, 1'b0, 1'b0, v_memwrite(1'b1, 1'b0));
        push(1'b0, 1'b0, 1'b0, v_memwrite(1'b0, 1'b0));
        push(1'b0, 1'b1, 1'b0, v_fault(2'b10));
        push(1'b0, 1'b0, 1'b0, v_fault(2'b10));
        push(1'b1, 1'b0, 1'b0, v_fault(2'b10));
        push(1'b0, 1'b0, 1'b0, v_fetch(1'b0, 2'd0));
        cyc = 0;
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s);
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL store cyc%0d: got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset_mid_write();
        stim_t s;
        logic [22:0] e;
        int cyc;
        cur_op = OP_STORE; cur_f3 = 3'b010; cur_f7 = 7'd0;
        push(1'b0, 1'b1, 1'b0, v_fetch(1'b1, 2'd0));
        push(1'b0, 1'b1, 1'b0, v_decode());
        push(1'b0, 1'b1, 1'b0, v_memadr(2'd1));
        push(1'b0, 1'b0, 1'b0, v_memwrite(1'b1, 1'b0));
        push(1'b1, 1'b1, 1'b0, v_memwrite(1'b0, 1'b0));
        cur_op = OP_R; cur_f3 = 3'b110;
        push(1'b0, 1'b1, 1'b0, v_fetch(1'b1, 2'd0));
        push(1'b0, 1'b1, 1'b0, v_decode());
        push(1'b0, 1'b1, 1'b0, ev(4'd6, 0, 0, 0, 0, 0, 2'd0, 2'd2, 2'd0, 2'd0, 3'b011, 0, 2'd0));
        push(1'b0, 1'b1, 1'b0, v_aluwb());
        cyc = 0;
        while (exp_q.size() != 0) begin
            s = stim_q.pop_front(); e = exp_q.pop_front();
            apply(s);
            n_checks++;
            if (w_obs !== e) begin
                n_fail++;
                $display("FAIL reset_mid_write cyc%0d: got %h expected %h", cyc, w_obs, e);
            end
            cyc++;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_jal();
        test_fetch_timeout();
        test_illegal();
        test_store();
        test_reset_mid_write();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
